// File: rtl/dot_product_feeder.sv
// Transmit side of the dot-product handshake: streams row/vector chunks plus two
// zero flush beats to the MAC controller, then captures its scalar result.
//
// state         | meaning
// S_IDLE        | waiting for start; degenerate jobs answered from here
// S_WAIT_READY  | holding until the controller raises I_am_ready
// S_FETCH       | chunk read strobe to the slice memory
// S_LOAD        | register masked row/vector chunk onto the buses
// S_FLUSH_LOAD  | load zeros onto both buses
// S_FLUSH_SLOT  | idle slot so flush beats cost the same as data beats
// S_PRESENT     | outsider_read_now strobe; beat count advances
// S_WAIT_FINISH | waiting for the controller's finish
module dot_product_feeder #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int max_total     = 128,
    parameter int addr_width    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    output logic                                 mem_rd_en,
    output logic [addr_width-1:0]                mem_addr,
    input  logic [element_width*no_of_units-1:0] row_data,
    input  logic [element_width*no_of_units-1:0] vec_data,
    output logic [element_width*no_of_units-1:0] first_row_plus_additional,
    output logic [element_width*no_of_units-1:0] vector2,
    output logic                                 outsider_read_now,
    input  logic                                 I_am_ready,
    input  logic                                 finish,
    input  logic [element_width-1:0]             dot_product_output,
    output logic [element_width-1:0]             result,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);
    localparam int BUS_W = element_width * no_of_units;
    localparam int CNT_W = addr_width + 2;
    localparam int REM_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_READY, S_FETCH, S_LOAD,
        S_FLUSH_LOAD, S_FLUSH_SLOT, S_PRESENT, S_WAIT_FINISH
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           beat_q, beat_d;
    logic [CNT_W-1:0]           n_chunks_q, n_chunks_d;
    logic [REM_W-1:0]           rem_q, rem_d;
    logic [BUS_W-1:0]           row_q, row_d;
    logic [BUS_W-1:0]           vec_q, vec_d;
    logic [element_width-1:0]   result_q, result_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic [BUS_W-1:0]           masked_row, masked_vec;
    logic                       last_chunk;
    logic [CNT_W-1:0]           beat_inc;

    assign last_chunk = (beat_q == n_chunks_q - CNT_W'(1));
    assign beat_inc   = beat_q + CNT_W'(1);

    // Lanes beyond the element count in a partial final chunk are zeroed.
    always_comb begin
        masked_row = row_data;
        masked_vec = vec_data;
        if (last_chunk && (rem_q != '0)) begin
            for (int i = 0; i < no_of_units; i++) begin
                if (i >= int'(rem_q)) begin
                    masked_row[i*element_width +: element_width] = '0;
                    masked_vec[i*element_width +: element_width] = '0;
                end
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        beat_d            = beat_q;
        n_chunks_d        = n_chunks_q;
        rem_d             = rem_q;
        row_d             = row_q;
        vec_d             = vec_q;
        result_d          = result_q;
        err_d             = err_q;
        done_d            = 1'b0;
        mem_rd_en         = 1'b0;
        outsider_read_now = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (total == 32'd0) begin
                        done_d   = 1'b1;
                        result_d = '0;
                        err_d    = 1'b0;
                    end else if (total > 32'(max_total)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        n_chunks_d = CNT_W'((total + 32'(no_of_units - 1)) / 32'(no_of_units));
                        rem_d      = REM_W'(total % 32'(no_of_units));
                        beat_d     = '0;
                        err_d      = 1'b0;
                        state_d    = S_WAIT_READY;
                    end
                end
            end
            S_WAIT_READY: begin
                if (I_am_ready) begin
                    state_d = (beat_q < n_chunks_q) ? S_FETCH : S_FLUSH_LOAD;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                row_d   = masked_row;
                vec_d   = masked_vec;
                state_d = S_PRESENT;
            end
            S_FLUSH_LOAD: begin
                row_d   = '0;
                vec_d   = '0;
                state_d = S_FLUSH_SLOT;
            end
            S_FLUSH_SLOT: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                // The strobe cycle also serves as the ready check, which keeps
                // back-to-back beats exactly three cycles apart.
                outsider_read_now = 1'b1;
                beat_d            = beat_inc;
                if (beat_inc < n_chunks_q + CNT_W'(2)) begin
                    if (I_am_ready) begin
                        state_d = (beat_inc < n_chunks_q) ? S_FETCH : S_FLUSH_LOAD;
                    end else begin
                        state_d = S_WAIT_READY;
                    end
                end else begin
                    state_d = S_WAIT_FINISH;
                end
            end
            S_WAIT_FINISH: begin
                if (finish) begin
                    result_d = dot_product_output;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            n_chunks_q <= '0;
            rem_q      <= '0;
            row_q      <= '0;
            vec_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            n_chunks_q <= n_chunks_d;
            rem_q      <= rem_d;
            row_q      <= row_d;
            vec_q      <= vec_d;
            result_q   <= result_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr                  = beat_q[addr_width-1:0];
    assign first_row_plus_additional = row_q;
    assign vector2                   = vec_q;
    assign result                    = result_q;
    assign busy                      = (state_q != S_IDLE);
    assign done                      = done_q;
    assign err                       = err_q;

endmodule

// File: tb/tb_dot_product_feeder.sv
// Randomized self-checking bench for dot_product_feeder; expected beats, timing
// and results come from the chunking rules applied to a bench-side memory image.
module tb_dot_product_feeder;
    localparam int W  = 32;
    localparam int U  = 8;
    localparam int BW = W * U;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   total;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] row_data, vec_data;
    logic [BW-1:0] first_row_plus_additional, vector2;
    logic          outsider_read_now;
    logic          I_am_ready;
    logic          finish;
    logic [W-1:0]  dot_product_output;
    logic [W-1:0]  result;
    logic          busy, done, err;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [BW-1:0] row_mem [16];
    logic [BW-1:0] vec_mem [16];
    logic [W-1:0]  exp_result = '0;

    dot_product_feeder dut (
        .clk(clk), .reset(reset), .start(start), .total(total),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .row_data(row_data), .vec_data(vec_data),
        .first_row_plus_additional(first_row_plus_additional), .vector2(vector2),
        .outsider_read_now(outsider_read_now), .I_am_ready(I_am_ready),
        .finish(finish), .dot_product_output(dot_product_output),
        .result(result), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Slice memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            row_data <= row_mem[mem_addr];
            vec_data <= vec_mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic fill_mem(input bit pattern);
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < U; l++) begin
                row_mem[k][l*W +: W] = pattern ? 32'(k + 1) : $urandom;
                vec_mem[k][l*W +: W] = pattern ? 32'(k + 1) : $urandom;
            end
        end
    endtask

    function automatic logic [BW-1:0] exp_beat(input bit is_vec, input int k, input int t);
        logic [BW-1:0] src, r;
        int n, lanes;
        n = (t + U - 1) / U;
        r = '0;
        if (k < n) begin
            src   = is_vec ? vec_mem[k] : row_mem[k];
            lanes = t - k * U;
            if (lanes > U) lanes = U;
            for (int l = 0; l < lanes; l++) r[l*W +: W] = src[l*W +: W];
        end
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobe"}, outsider_read_now, 0);
        chk({tag, "_rd_en"},  mem_rd_en, 0);
        chk({tag, "_addr"},   mem_addr, 0);
        chk({tag, "_row"},    first_row_plus_additional, 0);
        chk({tag, "_vec"},    vector2, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_err"},    err, 0);
    endtask

    task automatic run_job(input int t, input int stall_beat, input int stall_len,
                           input bit inj_start, input bit inj_finish,
                           input bit rand_fin, input logic [W-1:0] fin_val);
        int n, nb, cyc, beat, rd_cnt, exp_strobe, stall_until, fin_cyc, exp_done;
        bit waiting, got_done, inject;
        n = (t + U - 1) / U;
        nb = n + 2;
        beat = 0; rd_cnt = 0; exp_strobe = -1; stall_until = 0;
        fin_cyc = -1; exp_done = -1; waiting = 1'b1; got_done = 1'b0;
        @(negedge clk);
        start = 1'b1; total = 32'(t); I_am_ready = 1'b1; finish = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (cyc < 400 && !got_done) begin
            inject = 1'b0;
            if (cyc == 1) begin
                chk("busy_rise", busy, 1);
                chk("err_clear", err, 0);
            end
            if (mem_rd_en) begin
                chk("rd_addr", mem_addr, rd_cnt);
                chk("rd_cycle", cyc, exp_strobe - 2);
                rd_cnt++;
            end
            if (outsider_read_now) begin
                chk("strobe_cycle", cyc, exp_strobe);
                chk("beat_row", first_row_plus_additional, exp_beat(1'b0, beat, t));
                chk("beat_vec", vector2, exp_beat(1'b1, beat, t));
                if (inj_finish && beat == 1) inject = 1'b1;
                beat++;
                if (beat == stall_beat) stall_until = cyc + stall_len;
                if (beat < nb) waiting = 1'b1;
                else fin_cyc = cyc + 2;
            end
            if (done) begin
                chk("done_cycle", cyc, exp_done);
                chk("result", result, exp_result);
                chk("busy_fall", busy, 0);
                chk("err_after_job", err, 0);
                chk("beat_count", beat, nb);
                chk("read_count", rd_cnt, n);
                got_done = 1'b1;
            end else begin
                start = (cyc == 1) && inj_start;
                total = start ? 32'd5 : 32'(t);
                I_am_ready = (cyc >= stall_until);
                finish = 1'b0;
                if (cyc == fin_cyc) begin
                    finish = 1'b1;
                    dot_product_output = rand_fin ? $urandom : fin_val;
                    exp_result = dot_product_output;
                    exp_done = cyc + 1;
                end else if (inject) begin
                    finish = 1'b1;
                    dot_product_output = $urandom;
                end
                if (waiting && I_am_ready) begin
                    exp_strobe = cyc + 3;
                    waiting = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        start = 1'b0; finish = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", done, 0);
    endtask

    task automatic run_degen(input int t, input bit exp_err);
        int activity;
        if (t == 0) exp_result = '0;
        @(negedge clk);
        start = 1'b1; total = 32'(t);
        @(negedge clk);
        start = 1'b0;
        chk("degen_done", done, 1);
        chk("degen_err", err, exp_err);
        chk("degen_result", result, exp_result);
        chk("degen_busy", busy, 0);
        activity = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (outsider_read_now || mem_rd_en || done || busy) activity++;
        end
        chk("degen_quiet", activity, 0);
        chk("degen_err_sticky", err, exp_err);
    endtask

    task automatic reset_mid_beat();
        int strobes, activity;
        fill_mem(1'b0);
        @(negedge clk);
        start = 1'b1; total = 32'd16; I_am_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            if (outsider_read_now) strobes++;
            if (strobes == 3) break;
            @(negedge clk);
        end
        chk("rst_reached_beat2", strobes, 3);
        reset = 1'b0;
        #1;
        exp_result = '0;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outsider_read_now || mem_rd_en || done || busy) activity++;
        end
        chk("post_rst_quiet", activity, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; total = '0; I_am_ready = 1'b0;
        finish = 1'b0; dot_product_output = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        fill_mem(1'b1);
        run_job(16, 0, 0, 1'b0, 1'b0, 1'b0, 32'h40);
        fill_mem(1'b0);
        run_job(12, 0, 0, 1'b0, 1'b0, 1'b1, '0);
        fill_mem(1'b0);
        run_job(16, 1, 5, 1'b0, 1'b0, 1'b1, '0);
        fill_mem(1'b0);
        run_job(20, 0, 0, 1'b1, 1'b1, 1'b1, '0);

        run_degen(0, 1'b0);
        run_degen(200, 1'b1);
        run_degen(129, 1'b1);
        fill_mem(1'b0);
        run_job(8, 0, 0, 1'b0, 1'b0, 1'b1, '0);
        fill_mem(1'b0);
        run_job(128, 0, 0, 1'b0, 1'b0, 1'b1, '0);

        reset_mid_beat();

        for (int j = 0; j < 5; j++) begin
            fill_mem(1'b0);
            run_job(int'($urandom_range(1, 128)), int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
